// File: rtl/shift_seq_monitor_pkg.sv
// Shared types and helpers for the Johnson-sequence monitor.
package shift_seq_monitor_pkg;

    // Monitor FSM states
    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StLocked = 2'd1,
        StErr    = 2'd2
    } state_e;

    // Width of the saturating error-event counter
    localparam int unsigned ErrCntW = 8;

    // Widest counter johnson_next can handle; callers truncate to their own width
    localparam int unsigned MaxWidth = 64;

    // Johnson successor of v for a counter of the given width: shift left, feed back ~msb
    function automatic logic [MaxWidth-1:0] johnson_next(input logic [MaxWidth-1:0] v,
                                                          input int unsigned width);
        logic [MaxWidth-1:0] r;
        logic [5:0]          msb;
        msb  = 6'(width - 1);
        r    = {v[MaxWidth-2:0], 1'b0};
        r[0] = ~v[msb];
        return r;
    endfunction

endpackage

// File: rtl/shift_seq_monitor_phase_decode.sv
// johnson_phase_decode: combinational phase index and legality of one Johnson code.
// Legal codes are a low-side run of ones (0, 1, 3, ... all-ones) or a low-side run of
// zeros (..., 0xFC, 0xFE). Illegal codes decode to phase 0.
module johnson_phase_decode #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]             code,
    output logic [$clog2(2*WIDTH)-1:0]   phase,
    output logic                         legal
);

    localparam int unsigned PhaseW = $clog2(2 * WIDTH);

    logic [WIDTH-1:0] code_inv;
    logic             ones_run;
    logic             zeros_run;
    int unsigned      pop;

    // Legality via the x & (x+1) == 0 trick on the code and its complement, then phase
    always_comb begin
        code_inv  = ~code;
        ones_run  = ((code & (code + WIDTH'(1))) == '0);
        zeros_run = ((code_inv & (code_inv + WIDTH'(1))) == '0);
        legal     = ones_run | zeros_run;

        pop = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (code[i]) begin
                pop = pop + 1;
            end
        end

        phase = '0;
        if (legal && (code != '0)) begin
            if (code[0]) begin
                phase = PhaseW'(pop);
            end else begin
                phase = PhaseW'(2 * WIDTH - pop);
            end
        end
    end

endmodule

// File: rtl/shift_seq_monitor.sv
// shift_seq_monitor: checks an upstream Johnson counter, locks onto its sequence, and keeps
// sticky error flags plus error/cycle counters.
// Optional: SHIFT_SEQ_MONITOR_CYCLE_CNT_EN enables the completed-cycle counter; when
// undefined, cycle_cnt is tied to zero.
module shift_seq_monitor #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CYC_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in_count,
    input  logic                        in_j,
    input  logic                        clr_err,
    output logic [$clog2(2*WIDTH)-1:0]  phase,
    output logic                        locked,
    output logic                        seq_err,
    output logic                        j_err,
    output logic [7:0]                  err_cnt,
    output logic [CYC_W-1:0]            cycle_cnt
);

    import shift_seq_monitor_pkg::*;

    state_e               state_q, state_d;
    logic [3:0]           run_q, run_d;
    logic [WIDTH-1:0]     prev_q;
    logic                 locked_q, locked_d;
    logic                 seq_err_q, seq_err_d;
    logic                 j_err_q, j_err_d;
    logic [ErrCntW-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]     prev_next;
    logic                 prev_legal;
    logic                 good;
    logic                 in_locked;
    logic                 seq_set;
    logic                 j_set;

    // Phase output is the decode of the registered sample; legality of prev gates "good"
    johnson_phase_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .code  (prev_q),
        .phase (phase),
        .legal (prev_legal)
    );

    // Transition check: an illegal prev has an illegal successor, so checking prev suffices
    always_comb begin
        prev_next = WIDTH'(johnson_next(MaxWidth'(prev_q), WIDTH));
        good      = prev_legal && (in_count == prev_next);
        in_locked = (state_q == StLocked);
        seq_set   = in_locked && !good;
        j_set     = in_locked && ((in_j && (in_count != '0)) || (!in_j && (in_count == '0)));
    end

    // FSM next state and run counter
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        unique case (state_q)
            StHunt: begin
                if (good) begin
                    if (run_q == 4'(LOCK_CNT - 1)) begin
                        state_d = StLocked;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end else begin
                    run_d = '0;
                end
            end
            StLocked: begin
                if (!good) begin
                    state_d = StErr;
                end
            end
            StErr: begin
                state_d = StHunt;
                run_d   = '0;
            end
            default: begin
                state_d = StHunt;
                run_d   = '0;
            end
        endcase
        locked_d = (state_d == StLocked);
    end

    // Sticky flags and error counter; a new error outranks a simultaneous clear
    always_comb begin
        seq_err_d = seq_err_q;
        j_err_d   = j_err_q;
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            seq_err_d = 1'b0;
            j_err_d   = 1'b0;
            err_cnt_d = '0;
        end
        if (seq_set) begin
            seq_err_d = 1'b1;
            if (err_cnt_d != '1) begin
                err_cnt_d = err_cnt_d + ErrCntW'(1);
            end
        end
        if (j_set) begin
            j_err_d = 1'b1;
        end
    end

    // State and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StHunt;
            run_q     <= '0;
            prev_q    <= '0;
            locked_q  <= 1'b0;
            seq_err_q <= 1'b0;
            j_err_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            prev_q    <= in_count;
            locked_q  <= locked_d;
            seq_err_q <= seq_err_d;
            j_err_q   <= j_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign seq_err = seq_err_q;
    assign j_err   = j_err_q;
    assign err_cnt = err_cnt_q;

`ifdef SHIFT_SEQ_MONITOR_CYCLE_CNT_EN
    logic [CYC_W-1:0] cycle_cnt_q;

    // Completed-cycle counter: a good wrap into code 0 while locked, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q <= '0;
        end else if (in_locked && good && (in_count == '0) && (cycle_cnt_q != '1)) begin
            cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule
